// File: rtl/alu_core.sv
// Registered N-bit arithmetic/logic unit with clock enable and per-operand valid qualifiers.
// Latency: 1 edge for all commands; 2 edges for arithmetic multiplies (MODE=1, CMD 9/10).
// Backpressure: none; CE=0 freezes every output and any multiply in flight.
//
// Ports:
//   CLK, RST       clock (rising edge) and asynchronous active-low reset
//   INP_VALID[1:0] bit0 qualifies OPA, bit1 qualifies OPB
//   MODE, CMD      MODE=1 arithmetic, MODE=0 logical; CMD selects the operation
//   CE             clock enable; an edge with CE=1 accepts the presented command
//   OPA, OPB, CIN  operands and carry/borrow in
//   RES, ERR, OFLOW, COUT, G, L, E  registered result and flags
module alu_core #(
    parameter int N = 8
) (
    input  logic           CLK,
    input  logic           RST,
    input  logic [1:0]     INP_VALID,
    input  logic           MODE,
    input  logic [3:0]     CMD,
    input  logic           CE,
    input  logic [N-1:0]   OPA,
    input  logic [N-1:0]   OPB,
    input  logic           CIN,
    output logic           ERR,
    output logic [2*N-1:0] RES,
    output logic           OFLOW,
    output logic           COUT,
    output logic           G,
    output logic           L,
    output logic           E
);

    // Rotate amount width; N is expected to be a power of two, at least 4.
    localparam int SW = $clog2(N);

    localparam logic [N:0]     ONE_X = {{N{1'b0}}, 1'b1};
    localparam logic [2*N-1:0] ONE_W = {{(2*N-1){1'b0}}, 1'b1};

    // ------------------------------------------------------------------
    // Datapath helpers (N+1 bit so the carry/borrow lands in bit N)
    // ------------------------------------------------------------------
    logic [N:0]     a_x, b_x, cin_x;
    logic [N:0]     sum_ab, sum_abc, dif_ab, dif_abc;
    logic [N:0]     inc_a, dec_a, inc_b, dec_b;
    logic [2*N-1:0] rol_x, ror_x;
    logic [SW-1:0]  rot_amt;
    logic           rot_range_err;

    assign a_x     = {1'b0, OPA};
    assign b_x     = {1'b0, OPB};
    assign cin_x   = {{N{1'b0}}, CIN};
    assign sum_ab  = a_x + b_x;
    assign sum_abc = a_x + b_x + cin_x;
    assign dif_ab  = a_x - b_x;
    assign dif_abc = a_x - b_x - cin_x;
    assign inc_a   = a_x + ONE_X;
    assign dec_a   = a_x - ONE_X;
    assign inc_b   = b_x + ONE_X;
    assign dec_b   = b_x - ONE_X;

    // Rotations via a doubled copy of A: the wrapped bits fall into the kept half.
    assign rot_amt       = OPB[SW-1:0];
    assign rol_x         = {OPA, OPA} << rot_amt;
    assign ror_x         = {OPA, OPA} >> rot_amt;
    assign rot_range_err = |OPB[N-1:SW];

    // ------------------------------------------------------------------
    // Command decode for the presented inputs
    // ------------------------------------------------------------------
    logic [2*N-1:0] op_res;
    logic           op_err, op_oflow, op_cout, op_g, op_l, op_e;
    logic           op_mul, op_mul_sel, op_rot;
    logic           need_a, need_b, legal, missing;

    always_comb begin
        op_res     = '0;
        op_err     = 1'b0;
        op_oflow   = 1'b0;
        op_cout    = 1'b0;
        op_g       = 1'b0;
        op_l       = 1'b0;
        op_e       = 1'b0;
        op_mul     = 1'b0;
        op_mul_sel = 1'b0;
        op_rot     = 1'b0;
        need_a     = 1'b1;
        need_b     = 1'b1;
        legal      = 1'b1;

        if (MODE) begin
            case (CMD)
                4'd0: begin
                    op_res  = {{(N-1){1'b0}}, sum_ab};
                    op_cout = sum_ab[N];
                end
                4'd1: begin
                    op_res   = {{N{1'b0}}, dif_ab[N-1:0]};
                    op_oflow = dif_ab[N];
                end
                4'd2: begin
                    op_res  = {{(N-1){1'b0}}, sum_abc};
                    op_cout = sum_abc[N];
                end
                4'd3: begin
                    op_res   = {{N{1'b0}}, dif_abc[N-1:0]};
                    op_oflow = dif_abc[N];
                end
                4'd4: begin
                    need_b  = 1'b0;
                    op_res  = {{(N-1){1'b0}}, inc_a};
                    op_cout = inc_a[N];
                end
                4'd5: begin
                    need_b   = 1'b0;
                    op_res   = {{N{1'b0}}, dec_a[N-1:0]};
                    op_oflow = dec_a[N];
                end
                4'd6: begin
                    need_a  = 1'b0;
                    op_res  = {{(N-1){1'b0}}, inc_b};
                    op_cout = inc_b[N];
                end
                4'd7: begin
                    need_a   = 1'b0;
                    op_res   = {{N{1'b0}}, dec_b[N-1:0]};
                    op_oflow = dec_b[N];
                end
                4'd8: begin
                    op_g = (OPA > OPB);
                    op_l = (OPA < OPB);
                    op_e = (OPA == OPB);
                end
                4'd9:    op_mul = 1'b1;
                4'd10: begin
                    op_mul     = 1'b1;
                    op_mul_sel = 1'b1;
                end
                default: legal = 1'b0;
            endcase
        end else begin
            case (CMD)
                4'd0: op_res = {{N{1'b0}}, OPA & OPB};
                4'd1: op_res = {{N{1'b0}}, ~(OPA & OPB)};
                4'd2: op_res = {{N{1'b0}}, OPA | OPB};
                4'd3: op_res = {{N{1'b0}}, ~(OPA | OPB)};
                4'd4: op_res = {{N{1'b0}}, OPA ^ OPB};
                4'd5: op_res = {{N{1'b0}}, ~(OPA ^ OPB)};
                4'd6: begin
                    need_b = 1'b0;
                    op_res = {{N{1'b0}}, ~OPA};
                end
                4'd7: begin
                    need_a = 1'b0;
                    op_res = {{N{1'b0}}, ~OPB};
                end
                4'd8: begin
                    need_b = 1'b0;
                    op_res = {{N{1'b0}}, OPA >> 1};
                end
                4'd9: begin
                    need_b = 1'b0;
                    op_res = {{N{1'b0}}, OPA << 1};
                end
                4'd10: begin
                    need_a = 1'b0;
                    op_res = {{N{1'b0}}, OPB >> 1};
                end
                4'd11: begin
                    need_a = 1'b0;
                    op_res = {{N{1'b0}}, OPB << 1};
                end
                4'd12: begin
                    op_rot = 1'b1;
                    op_res = {{N{1'b0}}, rol_x[2*N-1:N]};
                end
                4'd13: begin
                    op_rot = 1'b1;
                    op_res = {{N{1'b0}}, ror_x[N-1:0]};
                end
                default: legal = 1'b0;
            endcase
        end

        missing = (need_a & ~INP_VALID[0]) | (need_b & ~INP_VALID[1]);

        if (!legal || missing) begin
            op_res   = '0;
            op_err   = 1'b1;
            op_oflow = 1'b0;
            op_cout  = 1'b0;
            op_g     = 1'b0;
            op_l     = 1'b0;
            op_e     = 1'b0;
            op_mul   = 1'b0;
        end else if (op_rot) begin
            // Out-of-range rotate amount is flagged but the rotated value is kept.
            op_err = rot_range_err;
        end
    end

    // ------------------------------------------------------------------
    // Multiply second stage: product formed from operands captured at accept
    // ------------------------------------------------------------------
    logic           mul_pend_q, mul_pend_d;
    logic           mul_sel_q, mul_sel_d;
    logic [N-1:0]   mul_a_q, mul_a_d;
    logic [N-1:0]   mul_b_q, mul_b_d;
    logic [2*N-1:0] mul_res;
    logic [2*N-1:0] mul_a_w, mul_b_w;
    logic           same_mul;

    always_comb begin
        mul_a_w = '0;
        mul_b_w = '0;
        if (mul_sel_q) begin
            mul_a_w = {{N{1'b0}}, mul_a_q[N-2:0], 1'b0};
            mul_b_w = {{N{1'b0}}, mul_b_q};
        end else begin
            mul_a_w = {{N{1'b0}}, mul_a_q} + ONE_W;
            mul_b_w = {{N{1'b0}}, mul_b_q} + ONE_W;
        end
        mul_res = mul_a_w * mul_b_w;
    end

    // Re-presenting the in-flight multiply (inputs held) or presenting no
    // operands at all lets it complete; anything else is a new command.
    assign same_mul = MODE && (INP_VALID == 2'b11) &&
                      (CMD == (mul_sel_q ? 4'd10 : 4'd9)) &&
                      (OPA == mul_a_q) && (OPB == mul_b_q);

    // ------------------------------------------------------------------
    // Output and pipeline registers
    // ------------------------------------------------------------------
    logic [2*N-1:0] res_q, res_d;
    logic           err_q, err_d;
    logic           oflow_q, oflow_d;
    logic           cout_q, cout_d;
    logic           g_q, g_d;
    logic           l_q, l_d;
    logic           e_q, e_d;

    always_comb begin
        res_d      = res_q;
        err_d      = err_q;
        oflow_d    = oflow_q;
        cout_d     = cout_q;
        g_d        = g_q;
        l_d        = l_q;
        e_d        = e_q;
        mul_pend_d = mul_pend_q;
        mul_sel_d  = mul_sel_q;
        mul_a_d    = mul_a_q;
        mul_b_d    = mul_b_q;

        if (CE) begin
            if (mul_pend_q && (same_mul || INP_VALID == 2'b00)) begin
                res_d      = mul_res;
                err_d      = 1'b0;
                oflow_d    = 1'b0;
                cout_d     = 1'b0;
                g_d        = 1'b0;
                l_d        = 1'b0;
                e_d        = 1'b0;
                mul_pend_d = 1'b0;
            end else begin
                // First multiply edge rewrites outputs to zero; product follows.
                res_d      = op_res;
                err_d      = op_err;
                oflow_d    = op_oflow;
                cout_d     = op_cout;
                g_d        = op_g;
                l_d        = op_l;
                e_d        = op_e;
                mul_pend_d = op_mul;
                if (op_mul) begin
                    mul_sel_d = op_mul_sel;
                    mul_a_d   = OPA;
                    mul_b_d   = OPB;
                end
            end
        end
    end

    always_ff @(posedge CLK or negedge RST) begin
        if (!RST) begin
            res_q      <= '0;
            err_q      <= 1'b0;
            oflow_q    <= 1'b0;
            cout_q     <= 1'b0;
            g_q        <= 1'b0;
            l_q        <= 1'b0;
            e_q        <= 1'b0;
            mul_pend_q <= 1'b0;
            mul_sel_q  <= 1'b0;
            mul_a_q    <= '0;
            mul_b_q    <= '0;
        end else begin
            res_q      <= res_d;
            err_q      <= err_d;
            oflow_q    <= oflow_d;
            cout_q     <= cout_d;
            g_q        <= g_d;
            l_q        <= l_d;
            e_q        <= e_d;
            mul_pend_q <= mul_pend_d;
            mul_sel_q  <= mul_sel_d;
            mul_a_q    <= mul_a_d;
            mul_b_q    <= mul_b_d;
        end
    end

    assign RES   = res_q;
    assign ERR   = err_q;
    assign OFLOW = oflow_q;
    assign COUT  = cout_q;
    assign G     = g_q;
    assign L     = l_q;
    assign E     = e_q;

endmodule

// File: tb/tb_alu_core.sv
// Directed testbench for alu_core (N=8) with hand-computed expected values.
// Inputs change 1 time unit after a rising edge; outputs are sampled there too.
// Ends with a single summary line.
module tb_alu_core;

    localparam int N = 8;

    logic           CLK;
    logic           RST;
    logic [1:0]     INP_VALID;
    logic           MODE;
    logic [3:0]     CMD;
    logic           CE;
    logic [N-1:0]   OPA;
    logic [N-1:0]   OPB;
    logic           CIN;
    logic           ERR;
    logic [2*N-1:0] RES;
    logic           OFLOW;
    logic           COUT;
    logic           G;
    logic           L;
    logic           E;

    int total = 0;
    int bad   = 0;

    alu_core #(.N(N)) dut (
        .CLK       (CLK),
        .RST       (RST),
        .INP_VALID (INP_VALID),
        .MODE      (MODE),
        .CMD       (CMD),
        .CE        (CE),
        .OPA       (OPA),
        .OPB       (OPB),
        .CIN       (CIN),
        .ERR       (ERR),
        .RES       (RES),
        .OFLOW     (OFLOW),
        .COUT      (COUT),
        .G         (G),
        .L         (L),
        .E         (E)
    );

    initial CLK = 1'b0;
    always #5 CLK = ~CLK;

    task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
        total++;
        if (obs !== exp) begin
            bad++;
            $display("FAIL %s: got %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge CLK);
        #1;
    endtask

    task automatic drive(input logic m, input logic [3:0] c, input logic [1:0] v,
                         input logic [7:0] a, input logic [7:0] b, input logic ci);
        MODE      = m;
        CMD       = c;
        INP_VALID = v;
        OPA       = a;
        OPB       = b;
        CIN       = ci;
    endtask

    initial begin
        RST = 1'b0;
        CE  = 1'b0;
        drive(1'b0, 4'd0, 2'b00, 8'h00, 8'h00, 1'b0);
        #12;
        chk("rst_res", RES, 16'h0000);
        chk("rst_flags", {11'd0, ERR, OFLOW, COUT, G, L, E}, 16'h0000);

        // ADD with carry, then reset asserted mid-cycle
        RST = 1'b1;
        CE  = 1'b1;
        drive(1'b1, 4'd0, 2'b11, 8'hFF, 8'h01, 1'b0);
        step();
        chk("add_res", RES, 16'h0100);
        chk("add_cout", {15'd0, COUT}, 16'h0001);
        #2;
        RST = 1'b0;
        #1;
        chk("rst_async_res", RES, 16'h0000);
        chk("rst_async_cout", {15'd0, COUT}, 16'h0000);
        step();
        chk("rst_hold_res", RES, 16'h0000);
        #2;
        RST = 1'b1;
        step();
        chk("add_after_rst_res", RES, 16'h0100);
        chk("add_after_rst_cout", {15'd0, COUT}, 16'h0001);

        // SUB
        drive(1'b1, 4'd1, 2'b11, 8'h05, 8'h07, 1'b0);
        step();
        chk("sub_neg_res", RES, 16'h00FE);
        chk("sub_neg_oflow", {15'd0, OFLOW}, 16'h0001);
        OPA = 8'h09;
        step();
        chk("sub_pos_res", RES, 16'h0002);
        chk("sub_pos_oflow", {15'd0, OFLOW}, 16'h0000);

        // ADD_CIN / SUB_CIN / DEC_A / INC_B
        drive(1'b1, 4'd2, 2'b11, 8'hFF, 8'h00, 1'b1);
        step();
        chk("addc_res", RES, 16'h0100);
        chk("addc_cout", {15'd0, COUT}, 16'h0001);
        drive(1'b1, 4'd3, 2'b11, 8'h05, 8'h05, 1'b1);
        step();
        chk("subc_res", RES, 16'h00FF);
        chk("subc_oflow", {15'd0, OFLOW}, 16'h0001);
        drive(1'b1, 4'd5, 2'b01, 8'h00, 8'h33, 1'b0);
        step();
        chk("deca_res", RES, 16'h00FF);
        chk("deca_flags", {14'd0, ERR, OFLOW}, 16'h0001);
        drive(1'b1, 4'd6, 2'b10, 8'h12, 8'hFF, 1'b0);
        step();
        chk("incb_res", RES, 16'h0100);
        chk("incb_flags", {14'd0, ERR, COUT}, 16'h0001);

        // CMP
        drive(1'b1, 4'd8, 2'b11, 8'h10, 8'h10, 1'b0);
        step();
        chk("cmp_eq", {13'd0, G, L, E}, 16'h0001);
        chk("cmp_eq_res", RES, 16'h0000);
        OPA = 8'h20;
        step();
        chk("cmp_gt", {13'd0, G, L, E}, 16'h0004);
        OPA = 8'h01;
        step();
        chk("cmp_lt", {13'd0, G, L, E}, 16'h0002);

        // Multiplies: inputs held over both edges
        drive(1'b1, 4'd9, 2'b11, 8'h03, 8'h04, 1'b0);
        step();
        chk("mul9_e1_err", {15'd0, ERR}, 16'h0000);
        step();
        chk("mul9_res", RES, 16'd20);
        drive(1'b1, 4'd10, 2'b11, 8'h03, 8'h04, 1'b0);
        step();
        step();
        chk("mul10_res", RES, 16'd24);

        // Multiply aborted by a new command in its second cycle
        drive(1'b1, 4'd9, 2'b11, 8'h03, 8'h04, 1'b0);
        step();
        drive(1'b1, 4'd0, 2'b11, 8'h01, 8'h02, 1'b0);
        step();
        chk("mul_abort_res", RES, 16'h0003);
        step();
        chk("mul_abort_late", RES, 16'h0003);

        // Multiply frozen by CE=0 between its two edges
        drive(1'b1, 4'd9, 2'b11, 8'h03, 8'h04, 1'b0);
        step();
        CE = 1'b0;
        step();
        step();
        CE = 1'b1;
        step();
        chk("mul_freeze_res", RES, 16'd20);

        // Arithmetic illegal command
        drive(1'b1, 4'd12, 2'b11, 8'h03, 8'h04, 1'b0);
        step();
        chk("arith_ill_err", {15'd0, ERR}, 16'h0001);
        chk("arith_ill_res", RES, 16'h0000);

        // Logical: NAND, rotates
        drive(1'b0, 4'd1, 2'b11, 8'hF0, 8'hCC, 1'b0);
        step();
        chk("nand_res", RES, 16'h003F);
        drive(1'b0, 4'd12, 2'b11, 8'b1000_0001, 8'h01, 1'b0);
        step();
        chk("rol_res", RES, 16'h0003);
        chk("rol_err", {15'd0, ERR}, 16'h0000);
        OPB = 8'h11;
        step();
        chk("rol_range_err", {15'd0, ERR}, 16'h0001);
        chk("rol_range_res", RES, 16'h0003);
        drive(1'b0, 4'd13, 2'b11, 8'b1000_0001, 8'h01, 1'b0);
        step();
        chk("ror_res", RES, 16'h00C0);

        // Missing operand, clock-enable hold, illegal logical command
        drive(1'b0, 4'd0, 2'b01, 8'hFF, 8'hFF, 1'b0);
        step();
        chk("miss_err", {15'd0, ERR}, 16'h0001);
        chk("miss_res", RES, 16'h0000);
        CE = 1'b0;
        drive(1'b0, 4'd2, 2'b11, 8'hF0, 8'h0F, 1'b0);
        step();
        chk("ce_hold_err", {15'd0, ERR}, 16'h0001);
        chk("ce_hold_res", RES, 16'h0000);
        CE = 1'b1;
        step();
        chk("ce_resume_res", RES, 16'h00FF);
        chk("ce_resume_err", {15'd0, ERR}, 16'h0000);
        drive(1'b0, 4'd15, 2'b11, 8'h12, 8'h34, 1'b0);
        step();
        chk("log_ill_err", {15'd0, ERR}, 16'h0001);
        chk("log_ill_res", RES, 16'h0000);

        // No operands at all
        drive(1'b0, 4'd6, 2'b00, 8'h12, 8'h34, 1'b0);
        step();
        chk("none_err", {15'd0, ERR}, 16'h0001);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/alu_core.md
Name: alu_core

Overview:
- Registered, parameterisable-width arithmetic/logic unit with a clock-enable and per-operand valid qualifiers.
- Sits behind a stimulus interface bundle and drives result, carry, overflow, compare and error flags.
- MODE selects arithmetic (1) or logical (0) command decoding.
- Single-cycle latency for all operations except the two multiply commands, which take two cycles.

Parameters:
N, 8, operand width in bits (OPA, OPB)

Ports:
CLK  in  1  clock, all state on rising edge
RST  in  1  reset; clears all outputs
INP_VALID  in  2  operand qualifiers: 00 none, 01 OPA only, 10 OPB only, 11 both
MODE  in  1  1 = arithmetic, 0 = logical
CMD  in  4  command code
CE  in  1  clock enable
OPA  in  N  operand A
OPB  in  N  operand B
CIN  in  1  carry/borrow in
ERR  out  1  illegal command or missing operand
RES  out  2N  result, zero-extended
OFLOW  out  1  overflow/underflow/borrow
COUT  out  1  carry out
G  out  1  A > B
L  out  1  A < B
E  out  1  A == B

Interface: one clock; reset is asynchronous and active-low. The reset port is RST and the clock port is CLK.

Behaviour:
- Reset (RST=0, asynchronous): RES, ERR, OFLOW, COUT, G, L and E all go to 0 immediately and stay 0 while RST is low.
- CE=0: every output holds its previous value, and any multiply in flight is frozen.
- Each accepted operation (CE=1) fully rewrites all outputs. Flags an operation does not define are 0.
- Result is registered on the edge where the inputs are sampled and is visible after that edge (latency 1). Commands 9 and 10 with MODE=1 are the exception: result appears one edge later (latency 2).
- A new command accepted during a multiply's second cycle aborts the multiply; the new command's result wins.
- Operand requirement: single-operand commands need their own operand's valid bit. Two-operand commands need INP_VALID=11.
- A missing required operand gives ERR=1 and RES=0.
- INP_VALID=00 gives ERR=1 for every command.
- Arithmetic commands (MODE=1), results are unsigned:
  - 0 ADD: RES=A+B; COUT=bit N of the sum.
  - 1 SUB: RES=(A-B) mod 2^N; OFLOW=1 if A<B.
  - 2 ADD_CIN: RES=A+B+CIN; COUT=bit N.
  - 3 SUB_CIN: RES=(A-B-CIN) mod 2^N; OFLOW=1 if A<B+CIN.
  - 4 INC_A: RES=A+1, keeping the carry in bit N, and COUT=bit N.
  - 5 DEC_A: RES=(A-1) mod 2^N; OFLOW=1 if A=0.
  - 6 INC_B and 7 DEC_B: same as 4 and 5, applied to B.
  - 8 CMP: RES=0; exactly one of G, L, E is 1.
  - 9: RES=(A+1)*(B+1), taken modulo 2^(2N).
  - 10: RES=((A<<1) mod 2^N)*B.
  - 11-15: ERR=1, RES=0.
- Logical commands (MODE=0); RES upper N bits are 0:
  - 0 AND, 1 NAND, 2 OR, 3 NOR, 4 XOR, 5 XNOR.
  - 6 NOT_A, 7 NOT_B.
  - 8 A>>1, 9 A<<1, 10 B>>1, 11 B<<1. Logical shifts within N bits, zero fill.
  - 12 ROL: rotate A left by OPB[log2N-1:0].
  - 13 ROR: rotate A right by OPB[log2N-1:0].
  - For 12 and 13, ERR=1 if any OPB bit above log2N-1 is set; RES still holds the rotated value.
  - 14-15: ERR=1, RES=0.
- CIN is ignored except by commands 2 and 3 in arithmetic mode.

Test Plan:
- RST=0 mid-operation with CE=1, MODE=1, CMD=0, OPA=8'hFF, OPB=8'h01 -> all outputs 0 immediately. Release reset, next edge -> RES=9'h100, COUT=1.
- MODE=1, CMD=1, OPA=8'h05, OPB=8'h07, INP_VALID=11 -> RES=8'hFE, OFLOW=1. Repeat with OPA=8'h09 -> RES=8'h02, OFLOW=0.
- MODE=1, CMD=8: OPA=8'h10 with OPB=8'h10 -> E=1, G=0, L=0. OPA=8'h20 -> G=1. OPA=8'h01 -> L=1.
- MODE=1, CMD=9, OPA=8'h03, OPB=8'h04 -> RES=20 two edges later (0 is not the result at edge 1). CMD=10 with the same operands -> RES=24.
- MODE=0, CMD=12, OPA=8'b1000_0001, OPB=8'h01 -> RES=8'b0000_0011, ERR=0. Same with OPB=8'h11 -> ERR=1.
- MODE=0, CMD=0, INP_VALID=01 -> ERR=1, RES=0. Then CE=0 with new inputs -> outputs unchanged. CMD=15 with INP_VALID=11 -> ERR=1.
